// File: rtl/pending_priority_encoder.sv
// rtl/pending_priority_encoder.sv - sticky pending vector with priority-encoded valid/ready output
// Requests accumulate in a pending register; one index at a time is presented and cleared on accept.
module pending_priority_encoder #(
   parameter int WIDTH = 16,
   parameter int OUT_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             enable,
   input  logic             msb_first,
   input  logic             flush,
   input  logic [WIDTH-1:0] req_in,
   input  logic             out_ready,
   output logic             out_valid,
   output logic [OUT_W-1:0] binary_out,
   output logic [OUT_W:0]   pend_count,
   output logic             ovf
);

   generate
      if (WIDTH < 2 || WIDTH > 64 || WIDTH > (1 << OUT_W)) begin : g_bad_params
         $error("pending_priority_encoder: WIDTH must be 2..64 and fit in OUT_W bits");
      end
   endgenerate

   logic [WIDTH-1:0] pending;
   logic [WIDTH-1:0] clr_mask;
   logic [WIDTH-1:0] src;
   logic [OUT_W-1:0] sel_idx;
   logic             accept;
   logic             ovf_next;

   always_comb begin
      accept   = out_valid & out_ready;
      clr_mask = '0;
      if (accept) begin
         for (int i = 0; i < WIDTH; i++) begin
            if (binary_out == OUT_W'(i)) clr_mask[i] = 1'b1;
         end
      end
      // Candidates for the next presentation exclude this cycle's req_in.
      src = pending & ~clr_mask;
      sel_idx = '0;
      if (msb_first) begin
         for (int i = 0; i < WIDTH; i++) begin
            if (src[i]) sel_idx = OUT_W'(i);
         end
      end else begin
         for (int i = WIDTH - 1; i >= 0; i--) begin
            if (src[i]) sel_idx = OUT_W'(i);
         end
      end
      ovf_next = enable & ~flush & (|(req_in & pending & ~clr_mask));
   end

   always_comb begin
      pend_count = '0;
      for (int i = 0; i < WIDTH; i++) begin
         pend_count = pend_count + {{OUT_W{1'b0}}, pending[i]};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending    <= '0;
         out_valid  <= 1'b0;
         binary_out <= '0;
         ovf        <= 1'b0;
      end else begin
         ovf <= ovf_next;
         if (flush) begin
            pending <= '0;
         end else begin
            pending <= src | (enable ? req_in : '0);
         end
         // A stalled index is held, so the consumer never sees it change under it.
         if (flush || !enable) begin
            out_valid <= 1'b0;
         end else if (!out_valid || accept) begin
            out_valid <= |src;
            if (|src) binary_out <= sel_idx;
         end
      end
   end

endmodule
